// File: rtl/sram_port_arbiter.sv
// Round-robin two-port arbiter/sequencer driving the single-port SRAM strobes; write 2 cycles, read 3 cycles to rvalid.
// Losing requester waits at most one access; optional shadow-parity check under PARITY_CHECK_EN.
module sram_port_arbiter #(
  parameter int MEM_WIDTH = 16,
  parameter int ADD_SIZE  = 10,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADD_SIZE-1:0]  a_addr,
  input  logic [MEM_WIDTH-1:0] a_wdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADD_SIZE-1:0]  b_addr,
  input  logic [MEM_WIDTH-1:0] b_wdata,
  output logic                 a_gnt,
  output logic                 b_gnt,
  output logic                 a_rvalid,
  output logic                 b_rvalid,
  output logic [MEM_WIDTH-1:0] rdata,
  output logic                 busy,
  output logic                 mem_blk_sel,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [ADD_SIZE-1:0]  mem_addr,
  output logic [MEM_WIDTH-1:0] mem_din,
  input  logic [MEM_WIDTH-1:0] mem_dout,
  input  logic                 mem_parity
`ifdef PARITY_CHECK_EN
  ,
  output logic                 parity_err,
  output logic                 parity_err_sticky
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

  state_t               state, state_nxt;
  logic                 last_b, last_b_nxt;
  logic                 pick_b;
  logic                 a_gnt_nxt, b_gnt_nxt, a_rv_nxt, b_rv_nxt;
  logic                 blk_nxt, rd_nxt, wr_nxt;
  logic [ADD_SIZE-1:0]  addr_nxt;
  logic [MEM_WIDTH-1:0] din_nxt, rdata_nxt;

  always_comb begin
    state_nxt  = state;
    last_b_nxt = last_b;
    a_gnt_nxt  = 1'b0;
    b_gnt_nxt  = 1'b0;
    a_rv_nxt   = 1'b0;
    b_rv_nxt   = 1'b0;
    blk_nxt    = 1'b0;
    rd_nxt     = 1'b0;
    wr_nxt     = 1'b0;
    addr_nxt   = mem_addr;
    din_nxt    = mem_din;
    rdata_nxt  = rdata;
    // B wins when alone, or on a tie when A was served last
    pick_b     = b_req & (~a_req | ~last_b);
    unique case (state)
      IDLE: begin
        if (a_req | b_req) begin
          state_nxt  = ACCESS;
          last_b_nxt = pick_b;
          a_gnt_nxt  = ~pick_b;
          b_gnt_nxt  = pick_b;
          blk_nxt    = 1'b1;
          wr_nxt     = pick_b ? b_we : a_we;
          rd_nxt     = ~wr_nxt;
          addr_nxt   = pick_b ? b_addr : a_addr;
          din_nxt    = pick_b ? b_wdata : a_wdata;
        end
      end
      ACCESS: begin
        if (mem_rd_en) begin
          state_nxt = CAPTURE;
          blk_nxt   = 1'b1;
          rd_nxt    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      CAPTURE: begin
        state_nxt = IDLE;
        rdata_nxt = mem_dout;
        a_rv_nxt  = ~last_b;
        b_rv_nxt  = last_b;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_b      <= 1'b1;
      a_gnt       <= 1'b0;
      b_gnt       <= 1'b0;
      a_rvalid    <= 1'b0;
      b_rvalid    <= 1'b0;
      rdata       <= '0;
      busy        <= 1'b0;
      mem_blk_sel <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
    end else begin
      state       <= state_nxt;
      last_b      <= last_b_nxt;
      a_gnt       <= a_gnt_nxt;
      b_gnt       <= b_gnt_nxt;
      a_rvalid    <= a_rv_nxt;
      b_rvalid    <= b_rv_nxt;
      rdata       <= rdata_nxt;
      busy        <= (state_nxt != IDLE);
      mem_blk_sel <= blk_nxt;
      mem_rd_en   <= rd_nxt;
      mem_wr_en   <= wr_nxt;
      mem_addr    <= addr_nxt;
      mem_din     <= din_nxt;
    end
  end

`ifdef PARITY_CHECK_EN
  logic [MEM_DEPTH-1:0] shadow;
  logic                 par_bad;

  assign par_bad = (mem_parity != shadow[mem_addr]);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      shadow            <= '0;
      parity_err        <= 1'b0;
      parity_err_sticky <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      if (state == ACCESS && mem_wr_en)
        shadow[mem_addr] <= ^mem_din;
      // judged at the same edge that raises rvalid, so the pulses line up
      if (state == CAPTURE) begin
        parity_err <= par_bad;
        if (par_bad)
          parity_err_sticky <= 1'b1;
      end
    end
  end
`else
  logic unused_parity;
  assign unused_parity = mem_parity ^ (MEM_DEPTH > 0);
`endif

endmodule
